// File: rtl/pcie_pack_pkg.sv
// Shared types and constants for the PCIe DMA burst packer.
// Holds the FSM state enum, the word size in bytes and the counter widths.
package pcie_pack_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    REQ  = 2'd1,
    SEND = 2'd2
  } state_e;

  localparam int BYTES_PER_WORD = 16;
  localparam int LEN_W          = 5;
  localparam int BCNT_W         = 16;

  // Index width for a buffer of n entries (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pcie_burst_buf.sv
// Burst staging buffer: BURST_LEN x DATA_WIDTH registers, no reset.
// Ports: clk; write port we/widx/wdata; asynchronous read port ridx/rdata.
module pcie_burst_buf #(
  parameter int BURST_LEN  = 8,
  parameter int DATA_WIDTH = 128,
  parameter int IDXW       = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDXW-1:0]       widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDXW-1:0]       ridx,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [BURST_LEN];

  always_ff @(posedge clk) begin
    if (we) mem_q[widx] <= wdata;
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/pcie_dma_burst_packer.sv
// Packs FIFO words into bursts, requests a DMA write, streams the burst out
// and advances a host ring offset. Ports: rd_clk/rd_rst_n (sync, active-low);
// enable; base_addr/ring_size; FIFO read port fifo_rd_*; DMA request
// dma_req/addr/len/ack; stream m_data/valid/ready/last; wr_offset, burst_cnt.
// Optional partial-burst flush: define PCIE_PACK_FLUSH_TIMEOUT_EN.
module pcie_dma_burst_packer
  import pcie_pack_pkg::*;
#(
  parameter int BURST_LEN   = 8,
  parameter int DATA_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] ring_size,
  input  logic                  fifo_rd_vld,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  dma_req,
  output logic [ADDR_WIDTH-1:0] dma_addr,
  output logic [LEN_W-1:0]      dma_len,
  input  logic                  dma_ack,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [ADDR_WIDTH-1:0] wr_offset,
  output logic [BCNT_W-1:0]     burst_cnt
);

  localparam int IDXW = idx_w(BURST_LEN);
  localparam logic [LEN_W-1:0] BLEN = LEN_W'(BURST_LEN);

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        fill_cnt_q, fill_cnt_d;
  logic [LEN_W-1:0]        rd_idx_q, rd_idx_d;
  logic [ADDR_WIDTH-1:0]   wr_off_q, wr_off_d;
  logic [BCNT_W-1:0]       bcnt_q, bcnt_d;
  logic [ADDR_WIDTH-1:0]   off_sum;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    pop, hs, last, tmo;

  assign pop  = (state_q == FILL) && enable && fifo_rd_vld
              && (fill_cnt_q < BLEN);
  assign hs   = (state_q == SEND) && m_ready;
  assign last = (rd_idx_q == fill_cnt_q - LEN_W'(1));

  assign off_sum = wr_off_q + ADDR_WIDTH'({fill_cnt_q, 4'b0000});

`ifdef PCIE_PACK_FLUSH_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;

  // Fires on the edge where the idle count would reach TIMEOUT_CYC.
  assign tmo = (state_q == FILL) && (fill_cnt_q != '0) && !pop
             && (idle_q == IDLE_W'(TIMEOUT_CYC - 1));

  always_comb begin
    idle_d = idle_q + IDLE_W'(1);
    if ((state_q != FILL) || (fill_cnt_q == '0) || pop || tmo)
      idle_d = '0;
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) idle_q <= '0;
    else           idle_q <= idle_d;
  end
`else
  logic unused_tmo;
  assign tmo        = 1'b0;
  assign unused_tmo = ^TIMEOUT_CYC;
`endif

  pcie_burst_buf #(
    .BURST_LEN (BURST_LEN),
    .DATA_WIDTH(DATA_WIDTH),
    .IDXW      (IDXW)
  ) u_buf (
    .clk  (rd_clk),
    .we   (pop),
    .widx (fill_cnt_q[IDXW-1:0]),
    .wdata(fifo_rd_data),
    .ridx (rd_idx_q[IDXW-1:0]),
    .rdata(rdata)
  );

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      state_q    <= FILL;
      fill_cnt_q <= '0;
      rd_idx_q   <= '0;
      wr_off_q   <= '0;
      bcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      rd_idx_q   <= rd_idx_d;
      wr_off_q   <= wr_off_d;
      bcnt_q     <= bcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    rd_idx_d   = rd_idx_q;
    wr_off_d   = wr_off_q;
    bcnt_d     = bcnt_q;
    unique case (state_q)
      FILL: begin
        if (pop) fill_cnt_d = fill_cnt_q + LEN_W'(1);
        if ((pop && (fill_cnt_q == BLEN - LEN_W'(1))) || tmo)
          state_d = REQ;
      end
      REQ: begin
        if (dma_ack) begin
          state_d  = SEND;
          rd_idx_d = '0;
        end
      end
      SEND: begin
        if (hs) rd_idx_d = rd_idx_q + LEN_W'(1);
        if (hs && last) begin
          state_d    = FILL;
          fill_cnt_d = '0;
          bcnt_d     = bcnt_q + BCNT_W'(1);
          // Wrap resets to zero rather than taking the remainder.
          wr_off_d   = (off_sum >= ring_size) ? '0 : off_sum;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    fifo_rd_en = pop;
    dma_req    = 1'b0;
    dma_addr   = '0;
    dma_len    = '0;
    m_valid    = 1'b0;
    m_data     = '0;
    m_last     = 1'b0;
    wr_offset  = wr_off_q;
    burst_cnt  = bcnt_q;
    unique case (state_q)
      REQ: begin
        dma_req  = 1'b1;
        dma_addr = base_addr + wr_off_q;
        dma_len  = fill_cnt_q;
      end
      SEND: begin
        m_valid = 1'b1;
        m_data  = rdata;
        m_last  = last;
      end
      default: ;
    endcase
  end

endmodule
